// File: rtl/quad_encoder_array_pkg.sv
// -----------------------------------------------------------------------------
// quad_encoder_array_pkg
//   Shared definitions for the quadrature encoder array: counting-mode
//   encodings, the per-transition decode result and the decode helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package quad_encoder_array_pkg;

   localparam logic [1:0] MODE_X1 = 2'b00;
   localparam logic [1:0] MODE_X2 = 2'b01;
   localparam logic [1:0] MODE_X4 = 2'b10;   // 2'b11 also decodes as x4

   typedef struct packed {
      logic valid;     // exactly one of A/B changed
      logic inc;       // count up in the current mode
      logic dec;       // count down in the current mode
      logic illegal;   // both A and B changed
   } qdec_t;

   // Width of a channel-select field; never zero, even for one channel.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // True when prev->cur follows the forward sequence 00->01->11->10->00.
   function automatic logic qfwd(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] nxt;
      case (prev)
         2'b00:   nxt = 2'b01;
         2'b01:   nxt = 2'b11;
         2'b11:   nxt = 2'b10;
         default: nxt = 2'b00;
      endcase
      return cur == nxt;
   endfunction

   // Classify one filtered {a,b} transition and decide whether it counts.
   function automatic qdec_t qdec(input logic [1:0] prev, input logic [1:0] cur,
                                  input logic [1:0] mode);
      qdec_t r;
      logic  cnt_en;
      logic  fwd;
      // NOTE: every variable gets a value before any branch, so no path leaves
      // one holding stale state (which would infer a latch in combinational use).
      r      = '0;
      cnt_en = 1'b0;
      fwd    = 1'b0;
      if (prev != cur) begin
         if ((prev ^ cur) == 2'b11) begin
            r.illegal = 1'b1;
         end else begin
            r.valid = 1'b1;
            fwd     = qfwd(prev, cur);
            case (mode)
               MODE_X1: cnt_en = !prev[1] && cur[1];    // A rising only
               MODE_X2: cnt_en = prev[1] != cur[1];     // any A edge
               default: cnt_en = 1'b1;                  // x4: every edge
            endcase
            r.inc = cnt_en && fwd;
            r.dec = cnt_en && !fwd;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/quad_encoder_array_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_array_if
//   Bundle of encoder pins, CPU preset/clear controls and per-channel results.
//   Signals:
//     enc_a/enc_b  raw encoder pins, one bit per channel
//     mode         global counting mode (x1/x2/x4)
//     wr_en/wr_ch/wr_data  counter preset strobe, channel and value
//     err_clr      per-channel sticky error clear
//     cnt          packed counts, channel i at [i*CW +: CW]
//     dir/step/err per-channel direction, count pulse and error flag
//   Modports: master drives pins/controls, slave is the encoder block.
// -----------------------------------------------------------------------------
interface quad_encoder_array_if #(
   parameter int NCH = 4,
   parameter int CW  = 32
);
   import quad_encoder_array_pkg::*;

   localparam int CHW = ch_width(NCH);

   logic [NCH-1:0]    enc_a;
   logic [NCH-1:0]    enc_b;
   logic [1:0]        mode;
   logic              wr_en;
   logic [CHW-1:0]    wr_ch;
   logic [CW-1:0]     wr_data;
   logic [NCH-1:0]    err_clr;
   logic [NCH*CW-1:0] cnt;
   logic [NCH-1:0]    dir;
   logic [NCH-1:0]    step;
   logic [NCH-1:0]    err;

   modport master (
      output enc_a, enc_b, mode, wr_en, wr_ch, wr_data, err_clr,
      input  cnt, dir, step, err
   );

   modport slave (
      input  enc_a, enc_b, mode, wr_en, wr_ch, wr_data, err_clr,
      output cnt, dir, step, err
   );

endinterface

// File: rtl/quad_encoder_array_ch.sv
// -----------------------------------------------------------------------------
// quad_decoder_ch
//   One encoder channel: pin synchronisers, per-pin deglitch filter, priming
//   after reset, quadrature decode and a modulo-2^CW position counter.
//   Ports:
//     clk, resetn          clock, synchronous active-low reset
//     a_raw, b_raw         asynchronous encoder pins
//     mode                 counting mode (x1/x2/x4)
//     preset_en/preset_data  load the counter (wins over a decode step)
//     err_clr              clear the sticky error (loses to a new illegal)
//     cnt, dir, step, err  position, last direction, count pulse, error
// -----------------------------------------------------------------------------
module quad_decoder_ch #(
   parameter int CW   = 32,
   parameter int SYNC = 2,
   parameter int FILT = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          a_raw,
   input  logic          b_raw,
   input  logic [1:0]    mode,
   input  logic          preset_en,
   input  logic [CW-1:0] preset_data,
   input  logic          err_clr,
   output logic [CW-1:0] cnt,
   output logic          dir,
   output logic          step,
   output logic          err
);
   import quad_encoder_array_pkg::*;

   localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;

   logic [SYNC-1:0] sync_a;
   logic [SYNC-1:0] sync_b;
   logic            s_a, s_b;     // synchronised pins
   logic            f_a, f_b;     // filtered pins
   logic            p_a, p_b;     // filtered pins one cycle earlier
   logic [FCW-1:0]  fc_a, fc_b;   // consecutive-difference counters
   logic            primed;
   qdec_t           dq;

   // NOTE: synchroniser flops carry no reset; they hold no state worth
   // clearing and flush themselves within SYNC cycles of any reset.
   always_ff @(posedge clk) begin
      sync_a <= {sync_a[SYNC-2:0], a_raw};
      sync_b <= {sync_b[SYNC-2:0], b_raw};
   end

   assign s_a = sync_a[SYNC-1];
   assign s_b = sync_b[SYNC-1];

   // Decoding the registered previous state against the filtered state adds
   // the final edge of the pin-to-count latency.
   always_comb dq = qdec({p_a, p_b}, {f_a, f_b}, mode);

   // NOTE: all state below updates with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         f_a    <= 1'b0;
         f_b    <= 1'b0;
         p_a    <= 1'b0;
         p_b    <= 1'b0;
         fc_a   <= '0;
         fc_b   <= '0;
         primed <= 1'b0;
         cnt    <= '0;
         dir    <= 1'b0;
         step   <= 1'b0;
         err    <= 1'b0;
      end else if (!primed) begin
         // Adopt whatever the pins show so a resting 11 is not seen as 00->11.
         f_a    <= s_a;
         f_b    <= s_b;
         p_a    <= s_a;
         p_b    <= s_b;
         primed <= 1'b1;
         step   <= 1'b0;
         if (preset_en) cnt <= preset_data;
      end else begin
         if (s_a == f_a) begin
            fc_a <= '0;
         end else if (fc_a == FCW'(FILT - 1)) begin
            f_a  <= s_a;
            fc_a <= '0;
         end else begin
            fc_a <= fc_a + FCW'(1);
         end

         if (s_b == f_b) begin
            fc_b <= '0;
         end else if (fc_b == FCW'(FILT - 1)) begin
            f_b  <= s_b;
            fc_b <= '0;
         end else begin
            fc_b <= fc_b + FCW'(1);
         end

         p_a <= f_a;
         p_b <= f_b;

         // Direction follows every legal edge, even ones the mode does not count.
         if (dq.valid) dir <= qfwd({p_a, p_b}, {f_a, f_b});

         if (dq.illegal)   err <= 1'b1;
         else if (err_clr) err <= 1'b0;

         if (preset_en) begin
            cnt  <= preset_data;
            step <= 1'b0;
         end else if (dq.inc) begin
            cnt  <= cnt + CW'(1);
            step <= 1'b1;
         end else if (dq.dec) begin
            cnt  <= cnt - CW'(1);
            step <= 1'b1;
         end else begin
            step <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/quad_encoder_array.sv
// -----------------------------------------------------------------------------
// quad_encoder_array
//   NCH-channel quadrature encoder interface. Replicates quad_decoder_ch per
//   channel, decodes the preset channel select and packs the counts.
//   Ports:
//     clk     system clock
//     resetn  synchronous active-low reset
//     bus     quad_encoder_array_if slave: pins, mode, preset, error clear
//             in; cnt/dir/step/err out
// -----------------------------------------------------------------------------
module quad_encoder_array #(
   parameter int NCH  = 4,
   parameter int CW   = 32,
   parameter int SYNC = 2,
   parameter int FILT = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   quad_encoder_array_if.slave   bus
);
   import quad_encoder_array_pkg::*;

   localparam int CHW = ch_width(NCH);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic preset_en;

      // Selects beyond NCH-1 match no channel and are dropped.
      assign preset_en = bus.wr_en && (bus.wr_ch == CHW'(i));

      quad_decoder_ch #(
         .CW   (CW),
         .SYNC (SYNC),
         .FILT (FILT)
      ) u_ch (
         .clk         (clk),
         .resetn      (resetn),
         .a_raw       (bus.enc_a[i]),
         .b_raw       (bus.enc_b[i]),
         .mode        (bus.mode),
         .preset_en   (preset_en),
         .preset_data (bus.wr_data),
         .err_clr     (bus.err_clr[i]),
         .cnt         (bus.cnt[i*CW +: CW]),
         .dir         (bus.dir[i]),
         .step        (bus.step[i]),
         .err         (bus.err[i])
      );
   end

endmodule
